// File: rtl/wavelet_conv_engine.sv
// Sample-by-sample FIR engine: circular sample history plus an external coefficient ROM,
// fed through a read -> multiply -> accumulate pipeline, then floor-shifted and saturated.
module wavelet_conv_engine #(
  parameter int TAPS   = 401,
  parameter int AW     = 9,
  parameter int IN_W   = 16,
  parameter int COEF_W = 32,
  parameter int ACC_W  = 57,
  parameter int SHIFT  = 15,
  parameter int OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [IN_W-1:0]   sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic [AW-1:0]            rom_addr,
  input  logic signed [COEF_W-1:0] rom_dout,
  output logic signed [OUT_W-1:0]  result,
  output logic                     result_valid
);
  localparam int PROD_W = IN_W + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            k_q, k_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     prod_valid_q, prod_valid_d;
  logic signed [IN_W-1:0]   hist_q, hist_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  result_q, result_d;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     result_valid_q, result_valid_d;

  logic                     mem_we;
  logic [AW-1:0]            mem_waddr;
  logic signed [IN_W-1:0]   mem_wdata;
  logic signed [IN_W-1:0]   hist_mem [TAPS];

  assign shifted = acc_q >>> SHIFT;

  generate
    if (OUT_W < ACC_W) begin : g_sat
      localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        sat_val = shifted[OUT_W-1:0];
        if (shifted > MAX_V)      sat_val = MAX_V[OUT_W-1:0];
        else if (shifted < MIN_V) sat_val = MIN_V[OUT_W-1:0];
      end
    end else begin : g_ext
      assign sat_val = OUT_W'(shifted);
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    k_d            = k_q;
    rd_valid_d     = (state_q == S_RUN);
    prod_valid_d   = rd_valid_q;
    hist_d         = hist_mem[rd_ptr_q];
    prod_d         = PROD_W'(hist_q) * PROD_W'(rom_dout);
    acc_d          = prod_valid_q ? acc_q + ACC_W'(prod_q) : acc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = wr_ptr_q;
    mem_wdata      = sample_in;

    case (state_q)
      // rd_ptr doubles as the clear index so rom_addr stays parked at 0 while clearing
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = rd_ptr_q;
        mem_wdata = '0;
        if (rd_ptr_q == LAST) begin
          rd_ptr_d = '0;
          state_d  = S_IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (sample_valid) begin
          mem_we   = 1'b1;
          rd_ptr_d = wr_ptr_q;
          k_d      = '0;
          acc_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - 1'b1;
        if (k_q == LAST) state_d = S_DRAIN;
        else             k_d     = k_q + 1'b1;
      end
      S_DRAIN: begin
        if (!rd_valid_q && !prod_valid_q) begin
          result_d       = sat_val;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_CLEAR;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      k_q            <= '0;
      rd_valid_q     <= 1'b0;
      prod_valid_q   <= 1'b0;
      hist_q         <= '0;
      prod_q         <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      k_q            <= k_d;
      rd_valid_q     <= rd_valid_d;
      prod_valid_q   <= prod_valid_d;
      hist_q         <= hist_d;
      prod_q         <= prod_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // History RAM has no reset; the CLEAR state zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) hist_mem[mem_waddr] <= mem_wdata;
  end

  assign sample_ready = (state_q == S_IDLE);
  assign rom_addr     = k_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
